// File: rtl/rf_writeback_queue.sv
// Write-side front end of the 32x32 register file: merges load and ALU write-backs
// into an in-order FIFO that drains one write per cycle. Define RF_WB_FWD_EN for forwarding lookups.
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                     Clk,
    input  logic                     Clr,
    input  logic                     LD_Valid,
    output logic                     LD_Ready,
    input  logic [4:0]               LD_Rd,
    input  logic [DW-1:0]            LD_Data,
    input  logic                     ALU_Valid,
    output logic                     ALU_Ready,
    input  logic [4:0]               ALU_Rd,
    input  logic [DW-1:0]            ALU_Data,
    output logic [4:0]               RW,
    output logic [DW-1:0]            PW,
    output logic                     LE,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty,
    output logic                     Full,
    input  logic [4:0]               RA,
    input  logic [4:0]               RB,
    output logic                     FA_Hit,
    output logic                     FB_Hit,
    output logic [DW-1:0]            FA_Data,
    output logic [DW-1:0]            FB_Data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    last_rd_q;
    logic [DW-1:0] last_data_q;

    logic [4:0]    rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [CW-1:0] free;
    logic          ld_fire, alu_fire;
    logic          ld_push, alu_push;
    logic          pop;
    logic [AW-1:0] alu_slot;

    // Space is judged on the registered count only; a same-edge pop earns no credit.
    assign free      = CW'(DEPTH) - count_q;
    assign LD_Ready  = (free >= CW'(1));
    assign ALU_Ready = LD_Valid ? (free >= CW'(2)) : (free >= CW'(1));

    assign ld_fire  = LD_Valid & LD_Ready;
    assign alu_fire = ALU_Valid & ALU_Ready;
    assign ld_push  = ld_fire & (LD_Rd != 5'd0);
    assign alu_push = alu_fire & (ALU_Rd != 5'd0);
    assign pop      = (count_q != '0);

    // The load belongs to the older instruction, so the ALU entry sits behind it.
    assign alu_slot = tail_q + AW'(ld_push);

    always_comb begin
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(ld_push) + AW'(alu_push);
        count_d = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            last_rd_q   <= '0;
            last_data_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pop) begin
                last_rd_q   <= rd_mem[head_q];
                last_data_q <= data_mem[head_q];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (ld_push) begin
            rd_mem[tail_q]   <= LD_Rd;
            data_mem[tail_q] <= LD_Data;
        end
        if (alu_push) begin
            rd_mem[alu_slot]   <= ALU_Rd;
            data_mem[alu_slot] <= ALU_Data;
        end
    end

    // When idle the write port holds whatever it last presented.
    assign LE    = pop;
    assign RW    = pop ? rd_mem[head_q]   : last_rd_q;
    assign PW    = pop ? data_mem[head_q] : last_data_q;
    assign Count = count_q;
    assign Empty = (count_q == '0);
    assign Full  = (count_q == CW'(DEPTH));

`ifdef RF_WB_FWD_EN
    logic [4:0]    look_addr [2];
    logic          look_hit  [2];
    logic [DW-1:0] look_data [2];
    logic [AW-1:0] scan_idx;

    assign look_addr[0] = RA;
    assign look_addr[1] = RB;

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        scan_idx = '0;
        for (int p = 0; p < 2; p++) begin
            look_hit[p]  = 1'b0;
            look_data[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                scan_idx = head_q + AW'(i);
                if ((CW'(i) < count_q) && (look_addr[p] != 5'd0) &&
                    (rd_mem[scan_idx] == look_addr[p])) begin
                    look_hit[p]  = 1'b1;
                    look_data[p] = data_mem[scan_idx];
                end
            end
        end
    end

    assign FA_Hit  = look_hit[0];
    assign FB_Hit  = look_hit[1];
    assign FA_Data = look_data[0];
    assign FB_Data = look_data[1];
`else
    assign FA_Hit  = 1'b0;
    assign FB_Hit  = 1'b0;
    assign FA_Data = '0;
    assign FB_Data = '0;
`endif

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side front end of the 32x32 PA-RISC register file: collects write-back results from the ALU path and the load path and drives the file's single write port (PW/RW/LE).
- Buffers up to DEPTH pending writes in a circular FIFO and issues one write per cycle in program order.
- Discards writes to GR0, which is hardwired zero.
- Optionally provides forwarding lookups so decode can read values that are still queued.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DW, 32, data width.

Ports:
- Clk  in  1  clock; all state updates on posedge
- Clr  in  1  asynchronous active-high reset
- LD_Valid  in  1  load result valid
- LD_Ready  out  1  load result accepted this cycle
- LD_Rd  in  5  load destination register
- LD_Data  in  DW  load data
- ALU_Valid  in  1  ALU result valid
- ALU_Ready  out  1  ALU result accepted this cycle
- ALU_Rd  in  5  ALU destination register
- ALU_Data  in  DW  ALU data
- RW  out  5  register file write address
- PW  out  DW  register file write data
- LE  out  1  register file load enable
- Count  out  $clog2(DEPTH)+1  occupied entries
- Empty  out  1  Count==0
- Full  out  1  Count==DEPTH
- RA, RB  in  5  forwarding lookup addresses
- FA_Hit, FB_Hit  out  1  lookup hit
- FA_Data, FB_Data  out  DW  forwarded data

Behaviour:
- Reset (async, Clr=1): head=tail=Count=0; Empty=1; Full=0; LE=0; RW=0; PW=0; FA_Hit=FB_Hit=0; FA_Data=FB_Data=0. Clr mid-operation drops all queued entries immediately; nothing is written after Clr.
- free = DEPTH-Count, taken from registered Count. No pop credit is given in the same cycle.
- LD_Ready = (free>=1).
- ALU_Ready = (free>=2) when LD_Valid=1, else (free>=1). Ready is combinational on Valid.
- Handshake: a transfer occurs on a posedge where Valid&Ready=1. A producer must hold Rd/Data stable while Valid=1 and Ready=0.
- Ordering: when both producers transfer on the same edge, the load entry is enqueued at tail and the ALU entry at tail+1. A load result always belongs to the older instruction.
- GR0 filter: a transfer with Rd==0 completes its handshake (Ready as above) but enqueues nothing and does not advance tail.
- Drain: when Count>0, RW/PW = head entry and LE=1. Head pops on the next posedge unconditionally, because the register file always accepts a write. When Count==0, LE=0 and RW/PW hold their last values.
- Latency: a transfer at edge N into an empty queue gives LE=1 during cycle N→N+1, and the register file captures the value at edge N+1.
- Count update per edge: Count' = Count + pushes − pop, where pushes ∈ {0,1,2}. Push and pop in the same edge are legal, including at Full (pop only) and at Count==1 (push plus pop).
- Pointers: head and tail wrap modulo DEPTH.
- Invariants: Count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Defined:
  - For each of RA and RB, combinationally search all valid entries; the youngest matching entry (closest to tail) wins.
  - On a match, FA_Hit/FB_Hit=1 and FA_Data/FB_Data carry that entry's data.
  - RA or RB ==0 never hits.
  - The entry currently at head (LE=1) is included in the search.
- Not defined: FA_Hit=FB_Hit=0 and FA_Data=FB_Data=0 constantly; no search logic is synthesized.

Test Plan:
- Reset/idle: Clr pulse mid-queue with Count=3 → Count=0, Empty=1, LE=0 in the same cycle; no further LE until a new transfer.
- Single write: ALU_Valid, Rd=5, Data=32'hDEADBEEF, empty queue → ALU_Ready=1; next cycle LE=1, RW=5, PW=32'hDEADBEEF; Empty=1 after the following edge.
- Dual push: LD(Rd=3, 32'h11) and ALU(Rd=4, 32'h22) on the same edge, Count=0 → writes appear on consecutive cycles in order RW=3 then RW=4.
- Backpressure at DEPTH=4 with Count=3 and both valid → LD_Ready=1, ALU_Ready=0; ALU is accepted on a later edge. At Full both readies are 0 and Count never exceeds 4.
- GR0 filter: ALU Rd=0, Data=32'hFFFFFFFF → handshake completes, Count unchanged, LE stays 0.
- Forwarding (RF_WB_FWD_EN): queue holds Rd=7:32'hA then Rd=7:32'hB; RA=7 → FA_Hit=1, FA_Data=32'hB. With RB=0 → FB_Hit=0. Without the macro, hits are always 0.
